// File: rtl/rv32i_types.sv
// Shared fetch-front-end types: FSM state encoding, default reset PC and the
// fetch packet layout for the default configuration.
package rv32i_types;

  localparam logic [31:0] RESET_PC_DEFAULT    = 32'h6000_0000;
  localparam int unsigned FETCH_WIDTH_DEFAULT = 2;
  localparam int unsigned INSTR_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    FS_RUN,
    FS_HOLD,
    FS_DISCARD
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]                                           pc;
    logic [FETCH_WIDTH_DEFAULT-1:0][INSTR_WIDTH_DEFAULT-1:0] instr;
    logic [FETCH_WIDTH_DEFAULT-1:0]                        valid;
  } fetch_packet_t;

endpackage

// File: rtl/fetch_valid_mask.sv
// Per-slot valid mask for a fetch block: slots below the entry offset are
// masked off, everything at or above it is valid.
module fetch_valid_mask #(
  parameter int unsigned FETCH_WIDTH = 2,
  localparam int unsigned OFF_W = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1
) (
  input  logic [OFF_W-1:0]       offset_i,
  output logic [FETCH_WIDTH-1:0] mask_o
);

  always_comb begin
    mask_o = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      mask_o[i] = (i >= int'(offset_i));
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: one aligned block per imem transaction, one
// packet per block into the queue. Define FETCH_PERF_EN for perf counters.
module fetch_unit
  import rv32i_types::*;
#(
  parameter int unsigned FETCH_WIDTH = 2,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT
) (
  input  logic                               clk,
  input  logic                               rst,
  output logic [31:0]                        imem_addr,
  output logic [FETCH_WIDTH*INSTR_WIDTH/8-1:0] imem_rmask,
  input  logic                               imem_resp,
  input  logic [FETCH_WIDTH*INSTR_WIDTH-1:0] imem_rdata,
  output logic                               fq_push,
  output logic [31:0]                        fq_pc,
  output logic [FETCH_WIDTH*INSTR_WIDTH-1:0] fq_instr,
  output logic [FETCH_WIDTH-1:0]             fq_valid,
  input  logic                               fq_full,
  input  logic                               redirect,
  input  logic [31:0]                        redirect_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]                        perf_blocks,
  output logic [31:0]                        perf_squashed,
  output logic [31:0]                        perf_stall_cycles
`endif
);

  localparam int unsigned BLK    = FETCH_WIDTH * 4;
  localparam int unsigned OFF_W  = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
  localparam int unsigned MASK_W = FETCH_WIDTH * INSTR_WIDTH / 8;
  localparam logic [31:0] BLK_LOW = 32'(BLK - 1);

  // Same shape as fetch_packet_t, but sized by this instance's parameters.
  typedef struct packed {
    logic [31:0]                           pc;
    logic [FETCH_WIDTH-1:0][INSTR_WIDTH-1:0] instr;
    logic [FETCH_WIDTH-1:0]                valid;
  } pkt_t;

  function automatic logic [31:0] align(input logic [31:0] x);
    return x & ~BLK_LOW;
  endfunction

  fetch_state_t             state_q, state_d;
  logic [31:0]              pc_q, pc_d;
  logic [31:0]              req_addr_q;
  pkt_t                     buf_q, buf_d;
  pkt_t                     out_pkt;
  logic [OFF_W-1:0]         req_off;
  logic [FETCH_WIDTH-1:0]   req_valid;
  logic                     issue;
  logic                     push;
  logic                     squash;

  assign req_off = pc_q[2 +: OFF_W] & OFF_W'(FETCH_WIDTH - 1);

  fetch_valid_mask #(
    .FETCH_WIDTH (FETCH_WIDTH)
  ) u_valid_mask (
    .offset_i (req_off),
    .mask_o   (req_valid)
  );

  // Redirect always wins over a push; issue marks a new request starting now.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    buf_d         = buf_q;
    issue         = 1'b0;
    push          = 1'b0;
    squash        = 1'b0;
    out_pkt.pc    = align(pc_q);
    out_pkt.instr = imem_rdata;
    out_pkt.valid = req_valid;
    case (state_q)
      FS_RUN: begin
        if (imem_resp) begin
          if (redirect) begin
            pc_d   = redirect_pc;
            issue  = 1'b1;
            squash = 1'b1;
          end else begin
            pc_d = align(pc_q) + 32'(BLK);
            if (fq_full) begin
              buf_d   = out_pkt;
              state_d = FS_HOLD;
            end else begin
              push  = 1'b1;
              issue = 1'b1;
            end
          end
        end else if (redirect) begin
          pc_d    = redirect_pc;
          state_d = FS_DISCARD;
        end
      end
      FS_DISCARD: begin
        if (redirect) pc_d = redirect_pc;
        if (imem_resp) begin
          squash  = 1'b1;
          issue   = 1'b1;
          state_d = FS_RUN;
        end
      end
      FS_HOLD: begin
        out_pkt = buf_q;
        if (redirect) begin
          pc_d    = redirect_pc;
          squash  = 1'b1;
          issue   = 1'b1;
          state_d = FS_RUN;
        end else if (!fq_full) begin
          push    = 1'b1;
          issue   = 1'b1;
          state_d = FS_RUN;
        end
      end
      default: state_d = FS_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FS_RUN;
      pc_q       <= RESET_PC;
      req_addr_q <= align(RESET_PC);
      buf_q      <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
      if (issue) req_addr_q <= align(pc_d);
    end
  end

  assign imem_addr  = rst ? align(RESET_PC) : (issue ? align(pc_d) : req_addr_q);
  assign imem_rmask = (!rst && (issue || (state_q != FS_HOLD && !imem_resp)))
                      ? {MASK_W{1'b1}} : {MASK_W{1'b0}};
  assign fq_push    = push && !rst;
  assign fq_pc      = out_pkt.pc;
  assign fq_instr   = out_pkt.instr;
  assign fq_valid   = fq_push ? out_pkt.valid : '0;

`ifdef FETCH_PERF_EN
  logic [31:0] blocks_q, squashed_q, stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blocks_q   <= '0;
      squashed_q <= '0;
      stall_q    <= '0;
    end else begin
      if (push && blocks_q != '1) blocks_q <= blocks_q + 32'd1;
      if (squash && squashed_q != '1) squashed_q <= squashed_q + 32'd1;
      if (state_q == FS_HOLD && stall_q != '1) stall_q <= stall_q + 32'd1;
    end
  end

  assign perf_blocks       = blocks_q;
  assign perf_squashed     = squashed_q;
  assign perf_stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit (FETCH_WIDTH=2) with a variable-latency imem
// model; expected packets are queued as stimulus is applied and popped on push.
module tb_fetch_unit;

  localparam int unsigned FW = 2;
  localparam int unsigned IW = 32;

  logic            clk;
  logic            rst;
  logic [31:0]     imem_addr;
  logic [7:0]      imem_rmask;
  logic            imem_resp;
  logic [63:0]     imem_rdata;
  logic            fq_push;
  logic [31:0]     fq_pc;
  logic [63:0]     fq_instr;
  logic [1:0]      fq_valid;
  logic            fq_full;
  logic            redirect;
  logic [31:0]     redirect_pc;
`ifdef FETCH_PERF_EN
  logic [31:0]     perf_blocks;
  logic [31:0]     perf_squashed;
  logic [31:0]     perf_stall_cycles;
`endif

  int checkCount = 0;
  int failCount  = 0;
  int memLat;

  typedef struct {
    logic [31:0] pc;
    logic [1:0]  valid;
    logic [63:0] instr;
  } expPkt_t;

  expPkt_t expQ[$];

  fetch_unit #(
    .FETCH_WIDTH (FW),
    .INSTR_WIDTH (IW),
    .RESET_PC    (32'h6000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_addr   (imem_addr),
    .imem_rmask  (imem_rmask),
    .imem_resp   (imem_resp),
    .imem_rdata  (imem_rdata),
    .fq_push     (fq_push),
    .fq_pc       (fq_pc),
    .fq_instr    (fq_instr),
    .fq_valid    (fq_valid),
    .fq_full     (fq_full),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_blocks       (perf_blocks),
    .perf_squashed     (perf_squashed),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Distinct, address-derived contents so stale or shifted data shows up.
  function automatic logic [63:0] blockData(input logic [31:0] a);
    return {(a + 32'd4) ^ 32'h5A5A_0000, a ^ 32'h0000_C3C3};
  endfunction

  // imem model: accepts a request when idle (or completing) and rmask is set,
  // answers memLat cycles later.
  logic        memBusy;
  int          memCnt;
  logic [31:0] memAddr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      memBusy <= 1'b0;
      memCnt  <= 0;
      memAddr <= 32'h0;
    end else if ((!memBusy || memCnt == 0) && imem_rmask != 8'h00) begin
      memBusy <= 1'b1;
      memAddr <= imem_addr;
      memCnt  <= memLat - 1;
    end else if (memBusy && memCnt == 0) begin
      memBusy <= 1'b0;
    end else if (memBusy) begin
      memCnt <= memCnt - 1;
    end
  end

  assign imem_resp  = memBusy && (memCnt == 0);
  assign imem_rdata = blockData(memAddr);

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic fullVal, input logic redirVal,
                               input logic [31:0] redirPcVal, input int latVal);
    @(posedge clk);
    #1;
    fq_full     = fullVal;
    redirect    = redirVal;
    redirect_pc = redirPcVal;
    memLat      = latVal;
  endtask

  task automatic expectPacket(input logic [31:0] pc, input logic [1:0] valid);
    expPkt_t p;
    p.pc    = pc;
    p.valid = valid;
    p.instr = blockData(pc);
    expQ.push_back(p);
  endtask

  // Scoreboard side: every push must match the oldest expected packet.
  always @(negedge clk) begin
    if (fq_push === 1'b1) begin
      expPkt_t e;
      checkOutput("pushWhileFull", 64'(fq_full), 64'(0));
      checkOutput("sbNonEmpty", 64'(expQ.size() != 0), 64'(1));
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        checkOutput("pushPc", 64'(fq_pc), 64'(e.pc));
        checkOutput("pushValid", 64'(fq_valid), 64'(e.valid));
        checkOutput("pushInstr", fq_instr, e.instr);
      end
    end
  end

  initial begin
    rst         = 1'b1;
    fq_full     = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    memLat      = 1;
    repeat (2) @(negedge clk);
    checkOutput("rstRmask", 64'(imem_rmask), 64'(0));
    checkOutput("rstPush", 64'(fq_push), 64'(0));
    checkOutput("rstValid", 64'(fq_valid), 64'(0));
    checkOutput("rstAddr", 64'(imem_addr), 64'h6000_0000);

    expectPacket(32'h6000_0000, 2'b11);
    expectPacket(32'h6000_0008, 2'b11);
    expectPacket(32'h6000_0010, 2'b11);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("firstAddr", 64'(imem_addr), 64'h6000_0000);
    checkOutput("firstRmask", 64'(imem_rmask), 64'hFF);
    checkOutput("firstNoPush", 64'(fq_push), 64'(0));

    applyStimulus(1'b0, 1'b0, 32'h0, 1);
    @(negedge clk);
    checkOutput("seqAddr1", 64'(imem_addr), 64'h6000_0008);
    applyStimulus(1'b0, 1'b0, 32'h0, 1);
    @(negedge clk);
    checkOutput("seqAddr2", 64'(imem_addr), 64'h6000_0010);

    // Queue full when the response for 0x60000010 arrives.
    applyStimulus(1'b1, 1'b0, 32'h0, 1);
    @(negedge clk);
    checkOutput("fullCapturePush", 64'(fq_push), 64'(0));
    checkOutput("fullCaptureRmask", 64'(imem_rmask), 64'(0));
    applyStimulus(1'b1, 1'b0, 32'h0, 1);
    @(negedge clk);
    checkOutput("holdPush", 64'(fq_push), 64'(0));
    checkOutput("holdRmask", 64'(imem_rmask), 64'(0));
    applyStimulus(1'b0, 1'b0, 32'h0, 3);
    @(negedge clk);
    checkOutput("drainPush", 64'(fq_push), 64'(1));
    checkOutput("drainNextAddr", 64'(imem_addr), 64'h6000_0018);

    // Redirect while 0x60000018 is outstanding with no response yet.
    applyStimulus(1'b0, 1'b1, 32'h6000_0104, 3);
    @(negedge clk);
    checkOutput("discardAddrHeld", 64'(imem_addr), 64'h6000_0018);
    checkOutput("discardRmask", 64'(imem_rmask), 64'hFF);
    applyStimulus(1'b0, 1'b0, 32'h0, 3);
    @(negedge clk);
    checkOutput("discardWaitAddr", 64'(imem_addr), 64'h6000_0018);
    checkOutput("discardWaitPush", 64'(fq_push), 64'(0));
    applyStimulus(1'b0, 1'b0, 32'h0, 1);
    expectPacket(32'h6000_0100, 2'b10);
    expectPacket(32'h6000_0108, 2'b11);
    @(negedge clk);
    checkOutput("discardDropPush", 64'(fq_push), 64'(0));
    checkOutput("discardTargetAddr", 64'(imem_addr), 64'h6000_0100);
    applyStimulus(1'b0, 1'b0, 32'h0, 1);
    @(negedge clk);
    checkOutput("partialNextAddr", 64'(imem_addr), 64'h6000_0108);
    applyStimulus(1'b0, 1'b0, 32'h0, 1);
    @(negedge clk);
    checkOutput("fullBlockNextAddr", 64'(imem_addr), 64'h6000_0110);

    // Redirect in the same cycle as the response.
    applyStimulus(1'b0, 1'b1, 32'h6000_0200, 1);
    @(negedge clk);
    checkOutput("coincidePush", 64'(fq_push), 64'(0));
    checkOutput("coincideAddr", 64'(imem_addr), 64'h6000_0200);

    // Capture 0x60000200 into the buffer, then redirect out of HOLD.
    applyStimulus(1'b1, 1'b0, 32'h0, 1);
    @(negedge clk);
    checkOutput("holdEntryPush", 64'(fq_push), 64'(0));
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFF8, 1);
    @(negedge clk);
    checkOutput("holdRedirPush", 64'(fq_push), 64'(0));
    checkOutput("holdRedirAddr", 64'(imem_addr), 64'hFFFF_FFF8);
    checkOutput("holdRedirRmask", 64'(imem_rmask), 64'hFF);

    // Address wrap at the top of the address space.
    applyStimulus(1'b0, 1'b0, 32'h0, 1);
    expectPacket(32'hFFFF_FFF8, 2'b11);
    expectPacket(32'h0000_0000, 2'b11);
    @(negedge clk);
    checkOutput("wrapAddr", 64'(imem_addr), 64'h0000_0000);
    applyStimulus(1'b0, 1'b0, 32'h0, 1);
    @(negedge clk);
    checkOutput("postWrapAddr", 64'(imem_addr), 64'h0000_0008);
`ifdef FETCH_PERF_EN
    checkOutput("perfBlocks", 64'(perf_blocks), 64'(6));
    checkOutput("perfSquashed", 64'(perf_squashed), 64'(3));
    checkOutput("perfStall", 64'(perf_stall_cycles), 64'(3));
`endif

    applyStimulus(1'b1, 1'b0, 32'h0, 1);
    @(negedge clk);
    checkOutput("finalHoldPush", 64'(fq_push), 64'(0));
    checkOutput("finalHoldRmask", 64'(imem_rmask), 64'(0));
    checkOutput("sbDrained", 64'(expQ.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
